// File: rtl/keypad_pkg.sv
// Shared types, constants and frame encoder for the keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_ROWS  = 3;
    localparam int unsigned NUM_COLS  = 3;
    localparam int unsigned NUM_KEYS  = NUM_ROWS * NUM_COLS;
    localparam int unsigned CODE_W    = 4;

    localparam logic [CODE_W-1:0] KEY_NONE = 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAND = 2'd1,
        HELD = 2'd2
    } deb_state_e;

    typedef enum logic [1:0] {
        FR_NONE  = 2'd0,
        FR_KEY   = 2'd1,
        FR_MULTI = 2'd2
    } frame_res_e;

    typedef struct packed {
        frame_res_e        res;
        logic [CODE_W-1:0] code;
    } frame_t;

    // Classify one full-keypad frame; bit i corresponds to key code i+1.
    function automatic frame_t encode_frame(input logic [NUM_KEYS-1:0] keys);
        frame_t      f;
        int unsigned cnt;
        f.res  = FR_NONE;
        f.code = KEY_NONE;
        cnt    = 0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (keys[i]) begin
                cnt    = cnt + 1;
                f.code = CODE_W'(i + 1);
            end
        end
        if (cnt == 1) begin
            f.res = FR_KEY;
        end else if (cnt > 1) begin
            f.res  = FR_MULTI;
            f.code = KEY_NONE;
        end
        return f;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Frame-level debouncer: accepts a press or release after DEBOUNCE_FRAMES identical frames.
module key_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_valid,
    input  frame_t            frame,
    output logic [CODE_W-1:0] button,
    output logic              bstate,
    output logic              key_held
);

    localparam int unsigned SW   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [SW-1:0] DF_W = SW'(DEBOUNCE_FRAMES);
    localparam logic [SW-1:0] ONE_W = SW'(1);

    deb_state_e        state_q, state_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [SW-1:0]     stable_q, stable_d;
    logic [CODE_W-1:0] button_q, button_d;
    logic              bstate_q, bstate_d;
    logic              key_held_q, key_held_d;
    logic [SW-1:0]     stable_inc_c;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cand_q     <= KEY_NONE;
            stable_q   <= '0;
            button_q   <= KEY_NONE;
            bstate_q   <= 1'b0;
            key_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            stable_q   <= stable_d;
            button_q   <= button_d;
            bstate_q   <= bstate_d;
            key_held_q <= key_held_d;
        end
    end

    // Next-state logic, evaluated only on frame boundaries.
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        stable_d     = stable_q;
        button_d     = button_q;
        bstate_d     = 1'b0;
        key_held_d   = key_held_q;
        stable_inc_c = (stable_q == DF_W) ? stable_q : stable_q + ONE_W;

        if (frame_valid) begin
            case (state_q)
                IDLE: begin
                    if (frame.res == FR_KEY) begin
                        cand_d = frame.code;
                        if (ONE_W == DF_W) begin
                            button_d   = frame.code;
                            bstate_d   = 1'b1;
                            key_held_d = 1'b1;
                            stable_d   = '0;
                            state_d    = HELD;
                        end else begin
                            stable_d = ONE_W;
                            state_d  = CAND;
                        end
                    end
                end
                CAND: begin
                    if (frame.res == FR_KEY && frame.code == cand_q) begin
                        if (stable_inc_c == DF_W) begin
                            button_d   = cand_q;
                            bstate_d   = 1'b1;
                            key_held_d = 1'b1;
                            stable_d   = '0;
                            state_d    = HELD;
                        end else begin
                            stable_d = stable_inc_c;
                        end
                    end else if (frame.res == FR_KEY) begin
                        cand_d   = frame.code;
                        stable_d = ONE_W;
                    end else begin
                        stable_d = '0;
                        state_d  = IDLE;
                    end
                end
                HELD: begin
                    if (frame.res == FR_NONE) begin
                        if (stable_inc_c == DF_W) begin
                            key_held_d = 1'b0;
                            stable_d   = '0;
                            state_d    = IDLE;
                        end else begin
                            stable_d = stable_inc_c;
                        end
                    end else begin
                        stable_d = '0;
                    end
                end
                default: begin
                    stable_d = '0;
                    state_d  = IDLE;
                end
            endcase
        end
    end

    assign button   = button_q;
    assign bstate   = bstate_q;
    assign key_held = key_held_q;

endmodule

// File: rtl/keypad_scanner.sv
// 3x3 keypad row scanner with column synchronizers, frame encoder and debouncer.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS      = 12000,
    parameter int unsigned DEBOUNCE_FRAMES = 20
) (
    input  logic              hwclk,
    input  logic              rst_n,
    output logic              keypad_r1,
    output logic              keypad_r2,
    output logic              keypad_r3,
    input  logic              keypad_c1,
    input  logic              keypad_c2,
    input  logic              keypad_c3,
    output logic [CODE_W-1:0] button,
    output logic              bstate,
    output logic              key_held
);

    localparam int unsigned DW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_TICKS - 1);
    localparam int unsigned ACC_W = (NUM_ROWS - 1) * NUM_COLS;

    logic [NUM_COLS-1:0] c_meta_q, c_meta_d;
    logic [NUM_COLS-1:0] c_sync_q, c_sync_d;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [1:0]          row_q, row_d;
    logic [NUM_ROWS-1:0] rows_n_q, rows_n_d;
    logic [ACC_W-1:0]    keys_q, keys_d;

    logic                sample_c;
    logic                frame_end_c;
    logic [NUM_COLS-1:0] cols_closed_c;
    logic [NUM_KEYS-1:0] frame_keys_c;
    frame_t              frame_c;

    // Scan, synchronizer and accumulator registers.
    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            c_meta_q <= 3'b111;
            c_sync_q <= 3'b111;
            dwell_q  <= '0;
            row_q    <= 2'd0;
            rows_n_q <= 3'b110;
            keys_q   <= '0;
        end else begin
            c_meta_q <= c_meta_d;
            c_sync_q <= c_sync_d;
            dwell_q  <= dwell_d;
            row_q    <= row_d;
            rows_n_q <= rows_n_d;
            keys_q   <= keys_d;
        end
    end

    // Dwell counter, row advance and per-row column capture.
    always_comb begin
        c_meta_d      = {keypad_c3, keypad_c2, keypad_c1};
        c_sync_d      = c_meta_q;
        dwell_d       = dwell_q + DW'(1);
        row_d         = row_q;
        rows_n_d      = rows_n_q;
        keys_d        = keys_q;
        cols_closed_c = ~c_sync_q;
        sample_c      = (dwell_q == DWELL_LAST);
        frame_end_c   = sample_c && (row_q == 2'd2);

        if (sample_c) begin
            dwell_d = '0;
            case (row_q)
                2'd0: begin
                    keys_d[2:0] = cols_closed_c;
                    row_d       = 2'd1;
                    rows_n_d    = 3'b101;
                end
                2'd1: begin
                    keys_d[5:3] = cols_closed_c;
                    row_d       = 2'd2;
                    rows_n_d    = 3'b011;
                end
                default: begin
                    keys_d   = '0;
                    row_d    = 2'd0;
                    rows_n_d = 3'b110;
                end
            endcase
        end
    end

    // Row 3 is classified straight from the synchronizer on the frame-end cycle.
    always_comb begin
        frame_keys_c = {cols_closed_c, keys_q};
        frame_c      = encode_frame(frame_keys_c);
    end

    key_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk        (hwclk),
        .rst_n      (rst_n),
        .frame_valid(frame_end_c),
        .frame      (frame_c),
        .button     (button),
        .bstate     (bstate),
        .key_held   (key_held)
    );

    assign keypad_r1 = rows_n_q[0];
    assign keypad_r2 = rows_n_q[1];
    assign keypad_r3 = rows_n_q[2];

endmodule
